// File: rtl/sf_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sf_bank
//  Description : Bank of WIDTH independent SF flip-flops with a global enable,
//                a parallel-load override, per-bit sticky change flags and a
//                saturating counter of edges on which any bit of Q changed.
//
//                SF control per bit (S,F): 00 clear, 01 set, 10 hold, 11 toggle.
//
//  Ports       : clk      - rising-edge clock
//                rst_n    - asynchronous active-low reset
//                en       - enables SF update of all channels
//                ld       - parallel load strobe (overrides en)
//                ld_val   - value loaded into Q when ld=1
//                S, F     - per-channel SF controls
//                clr      - clears changed flags and chg_cnt (clear-then-record)
//                Q        - channel state (registered)
//                changed  - sticky per-bit change flags (registered)
//                chg_cnt  - saturating count of changing edges (registered)
//                cnt_sat  - high when chg_cnt is at its maximum
//  Revision    : 1.0 - initial release
// ============================================================================
module sf_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] F,
  input  logic             clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] changed,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] delta;
  logic             any_change;

  always_comb begin
    q_d = q_q;
    // Load wins over enable; S/F are only examined on an enabled, non-load
    // edge so unknown controls cannot leak into Q while the bank is idle.
    if (ld) begin
      q_d = ld_val;
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({S[i], F[i]})
          2'b00:   q_d[i] = 1'b0;
          2'b01:   q_d[i] = 1'b1;
          2'b10:   q_d[i] = q_q[i];
          default: q_d[i] = ~q_q[i];
        endcase
      end
    end

    delta      = q_d ^ q_q;
    any_change = |delta;

    // A clearing edge still records its own change so nothing is lost.
    if (clr) begin
      changed_d = delta;
      cnt_d     = any_change ? CNT_ONE : '0;
    end else begin
      changed_d = changed_q | delta;
      if (any_change && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= '0;
      changed_q <= '0;
      cnt_q     <= '0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Q       = q_q;
  assign changed = changed_q;
  assign chg_cnt = cnt_q;
  assign cnt_sat = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_sf_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sf_bank
//  Description : Self-checking bench for sf_bank (WIDTH=4, CNT_W=2). A
//                behavioural reference model follows the bank on every edge
//                and is compared against the DUT on every falling edge; the
//                directed scenarios also carry hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sf_bank;

  localparam int WIDTH   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] F;
  logic             clr;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] changed;
  logic [CNT_W-1:0] chg_cnt;
  logic             cnt_sat;

  int n_cmp;
  int n_bad;

  sf_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .ld     (ld),
    .ld_val (ld_val),
    .S      (S),
    .F      (F),
    .clr    (clr),
    .Q      (Q),
    .changed(changed),
    .chg_cnt(chg_cnt),
    .cnt_sat(cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_q   [WIDTH];
  bit m_chg [WIDTH];
  int m_cnt;

  function automatic int pack_bits(input bit b [WIDTH]);
    int v = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) v += (1 << i);
    return v;
  endfunction

  always @(negedge rst_n) begin
    for (int i = 0; i < WIDTH; i++) begin
      m_q[i]   = 1'b0;
      m_chg[i] = 1'b0;
    end
    m_cnt = 0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      bit nq [WIDTH];
      bool_t: begin end
      begin
        bit any;
        any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          nq[i] = m_q[i];
          if (ld) nq[i] = ld_val[i];
          else if (en) begin
            if (!S[i] && !F[i]) nq[i] = 1'b0;        // clear
            else if (!S[i] && F[i]) nq[i] = 1'b1;    // set
            else if (S[i] && F[i]) nq[i] = !m_q[i];  // toggle
          end
        end
        for (int i = 0; i < WIDTH; i++) begin
          bit d;
          d = (nq[i] != m_q[i]);
          if (d) any = 1'b1;
          m_chg[i] = clr ? d : (m_chg[i] | d);
          m_q[i]   = nq[i];
        end
        if (clr) m_cnt = any ? 1 : 0;
        else if (any && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
    end
  end

  // Compare process: outputs are settled mid-cycle.
  bit cmp_on;
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_Q",       int'(Q),       pack_bits(m_q));
      check("model_changed", int'(changed), pack_bits(m_chg));
      check("model_chg_cnt", int'(chg_cnt), m_cnt);
      check("model_cnt_sat", int'(cnt_sat), (m_cnt == CNT_MAX) ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic e, input logic l, input logic [WIDTH-1:0] lv,
                      input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] f,
                      input logic c);
    @(negedge clk);
    en = e; ld = l; ld_val = lv; S = s; F = f; clr = c;
    @(posedge clk);
    #1;
  endtask

  // Bit0 SF sequence: (S,F) pairs and the Q[0] each must produce.
  logic [1:0] seq_sf [6];
  int         seq_q  [6];

  initial begin
    n_cmp = 0; n_bad = 0; cmp_on = 1'b0;
    rst_n = 1'b0; en = 1'b0; ld = 1'b0; ld_val = '0; S = '0; F = '0; clr = 1'b0;
    seq_sf[0] = 2'b01; seq_q[0] = 1;
    seq_sf[1] = 2'b11; seq_q[1] = 0;
    seq_sf[2] = 2'b01; seq_q[2] = 1;
    seq_sf[3] = 2'b10; seq_q[3] = 1;
    seq_sf[4] = 2'b00; seq_q[4] = 0;
    seq_sf[5] = 2'b11; seq_q[5] = 1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_Q", int'(Q), 0);
    check("reset_changed", int'(changed), 0);
    check("reset_cnt", int'(chg_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_on = 1'b1;

    // SF truth table on bit0; other bits hold (S=1,F=0).
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 4'h0, {3'b111, seq_sf[k][1]}, {3'b000, seq_sf[k][0]}, 1'b0);
      check($sformatf("sf_seq%0d_Q0", k), int'(Q[0]), seq_q[k]);
    end
    check("sf_cnt", int'(chg_cnt), 3);
    check("sf_sat", int'(cnt_sat), 1);
    check("sf_changed", int'(changed), 4'b0001);

    // Enable/load priority.
    repeat (3) step(1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0);
    check("en0_hold_Q", int'(Q), 4'b0001);
    step(1'b1, 1'b1, 4'b1010, 4'hF, 4'hF, 1'b0);
    check("ld_override_Q", int'(Q), 4'b1010);

    // Return to Q=0000 with everything cleared.
    step(1'b0, 1'b1, 4'b0000, 4'h0, 4'h0, 1'b1);
    check("clr_record_changed", int'(changed), 4'b1010);
    check("clr_record_cnt", int'(chg_cnt), 1);
    step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

    // Sticky / clear.
    step(1'b1, 1'b0, 4'h0, 4'b1011, 4'b0100, 1'b0);
    check("set_b2_changed", int'(changed), 4'b0100);
    step(1'b1, 1'b0, 4'h0, 4'b1111, 4'b0010, 1'b1);
    check("clr_tog_changed", int'(changed), 4'b0010);
    check("clr_tog_cnt", int'(chg_cnt), 1);
    step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    check("clr_idle_changed", int'(changed), 4'b0000);
    check("clr_idle_cnt", int'(chg_cnt), 0);

    // Saturation: toggle bit0 five times.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 4'h0, 4'b1111, 4'b0001, 1'b0);
      check($sformatf("sat_cnt%0d", k), int'(chg_cnt), (k < 3) ? k + 1 : 3);
      check($sformatf("sat_flag%0d", k), int'(cnt_sat), (k >= 2) ? 1 : 0);
    end
    step(1'b1, 1'b0, 4'h0, 4'b1111, 4'b0001, 1'b0);
    check("pre_ld_Q", int'(Q), 4'b0110);

    // No-change load.
    step(1'b0, 1'b1, 4'b0110, 4'h0, 4'h0, 1'b0);
    check("nochg_ld_changed", int'(changed), 4'b0001);
    check("nochg_ld_cnt", int'(chg_cnt), 3);

    // Asynchronous reset mid-cycle, checked before any edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_Q", int'(Q), 0);
    check("async_rst_changed", int'(changed), 0);
    check("async_rst_cnt", int'(chg_cnt), 0);
    check("async_rst_sat", int'(cnt_sat), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           4'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sf_bank.md
Name: sf_bank

Overview:
- Parametrised bank of WIDTH independent SF flip-flops sharing one clock.
- Adds the following to the single-bit SF cell:
  - global enable
  - parallel load override
  - per-bit sticky change flags
  - saturating counter of edges on which the bank changed state
- Used as a status/control register bank wherever SF-style set/hold/toggle/clear control is needed per bit, with software-visible change tracking.

Parameters:
- WIDTH, 8, number of SF channels (≥1)
- CNT_W, 4, width of change-event counter (≥1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  enables SF update of all channels
- ld  input  1  parallel load strobe; overrides en
- ld_val  input  WIDTH  value loaded into Q when ld=1
- S  input  WIDTH  per-channel S control
- F  input  WIDTH  per-channel F control
- clr  input  1  clears changed flags and chg_cnt
- Q  output  WIDTH  channel state
- changed  output  WIDTH  sticky per-bit flag, set when the bit of Q changed value
- chg_cnt  output  CNT_W  saturating count of edges on which Q changed (any bit)
- cnt_sat  output  1  high when chg_cnt = 2^CNT_W-1

Behaviour:
- Reset: rst_n=0 asynchronously forces Q=0, changed=0, chg_cnt=0, cnt_sat=0, independent of clk. Release is sampled on the next rising edge. Reset mid-operation discards all state.
- SF per-bit function, applied when en=1 and ld=0, bit i using S[i],F[i]:
  - 00 → Q[i]=0 (clear)
  - 01 → Q[i]=1 (set)
  - 10 → Q[i] holds
  - 11 → Q[i] toggles
- en=0 and ld=0: Q holds regardless of S/F.
- ld=1: Q ← ld_val, regardless of en, S, F.
- Latency: Q reflects the inputs sampled on an edge immediately after that edge (one register stage, no combinational path from inputs to Q).
- Define delta = Q_next XOR Q (computed per edge).
- changed:
  - clr=0: changed ← changed OR delta
  - clr=1: changed ← delta (clear-then-record; a change on the clearing edge is not lost)
- chg_cnt:
  - clr=0: increments by 1 when delta≠0; holds at 2^CNT_W-1 (no wrap); holds when delta=0
  - clr=1: chg_cnt ← (delta≠0) ? 1 : 0
- A load equal to the current Q gives delta=0: no flag set, no count.
- cnt_sat is combinational from chg_cnt.
- All outputs are registered except cnt_sat. No X propagation from unused S/F when en=0.

Test Plan (WIDTH=4, CNT_W=2):
1. Reset:
   - rst_n=0 asserted between edges → Q=0000, changed=0000, chg_cnt=0 immediately, without a clock edge.
2. SF truth table (en=1, bit0, starting Q=0) → Q[0] after each edge:
   - S,F=01 → 1
   - S,F=11 → 0
   - S,F=01 → 1
   - S,F=10 → 1
   - S,F=00 → 0
   - S,F=11 → 1
   - Resulting counts: chg_cnt=3 (saturated, cnt_sat=1), changed[0]=1.
3. Enable/load priority:
   - en=0, S=F=1111, 3 edges → Q unchanged.
   - ld=1, ld_val=1010 with en=1, S=F=1111 → Q=1010, not toggled.
4. Sticky/clear:
   - From Q=0000, set bit2 → changed=0100.
   - Then clr=1 while toggling bit1 on the same edge → changed=0010, chg_cnt=1.
   - Next edge with clr=1 and no change → changed=0000, chg_cnt=0.
5. Saturation:
   - 5 consecutive toggling edges after clr → chg_cnt sequence 1,2,3,3,3; cnt_sat=1 from the 3rd edge.
6. No-change load:
   - Q=0110, ld=1, ld_val=0110 → changed and chg_cnt unchanged.
